// File: rtl/sprite_tile_engine.sv
// Sprite tile renderer: 2-stage pixel pipeline fetching palette indices from a synchronous tile ROM.
// Optional horizontal mirroring is compiled in when SPRITE_FLIP_EN is defined.
module sprite_tile_engine #(
  parameter int          SPR_W      = 32,
  parameter int          SPR_H      = 32,
  parameter int          SCALE_LOG2 = 0,
  parameter int          N_TILES    = 8,
  parameter int          IDX_W      = 4,
  parameter int          KEY_IDX    = 0,
  parameter logic [11:0] BG_RGB     = 12'h000,
  localparam int         ADDR_W     = $clog2(N_TILES * SPR_W * SPR_H),
  localparam int         TILE_W     = (N_TILES > 1) ? $clog2(N_TILES) : 1
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [TILE_W-1:0] tile_sel,
`ifdef SPRITE_FLIP_EN
  input  logic              flip_x,
`endif
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [11:0]       pal_rgb,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              sprite_on
);

  localparam int          CW     = $clog2(SPR_W);
  localparam int          RW     = $clog2(SPR_H);
  localparam logic [10:0] SPAN_X = 11'(SPR_W << SCALE_LOG2);
  localparam logic [10:0] SPAN_Y = 11'(SPR_H << SCALE_LOG2);

  logic [9:0]        px_q, px_d;
  logic [9:0]        py_q, py_d;
  logic [TILE_W-1:0] tsel_q, tsel_d;
`ifdef SPRITE_FLIP_EN
  logic              fx_q, fx_d;
`endif
  logic              hit_q, hit_d;
  logic              blank_q, blank_d;
  logic [11:0]       rgb_q, rgb_d;
  logic              sprite_on_q, sprite_on_d;

  logic [10:0]       dx, dy;
  logic              hit;
  logic [CW-1:0]     col;
  logic [CW-1:0]     col_raw;
  logic [RW-1:0]     row;
  logic [TILE_W+RW+CW-1:0] addr_full;

  // Shadow registers: the sprite setup only changes between frames.
  always_comb begin
    px_d   = px_q;
    py_d   = py_q;
    tsel_d = tsel_q;
`ifdef SPRITE_FLIP_EN
    fx_d   = fx_q;
`endif
    if (frame_start) begin
      px_d = pos_x;
      py_d = pos_y;
      if ({{(32-TILE_W){1'b0}}, tile_sel} >= 32'(N_TILES))
        tsel_d = TILE_W'(N_TILES - 1);
      else
        tsel_d = tile_sel;
`ifdef SPRITE_FLIP_EN
      fx_d = flip_x;
`endif
    end
  end

  // 11-bit offsets: a sprite hanging past column 1023 clips instead of wrapping.
  always_comb begin
    dx      = {1'b0, DrawX} - {1'b0, px_q};
    dy      = {1'b0, DrawY} - {1'b0, py_q};
    hit     = ({1'b0, DrawX} >= {1'b0, px_q}) && (dx < SPAN_X) &&
              ({1'b0, DrawY} >= {1'b0, py_q}) && (dy < SPAN_Y);
    col_raw = dx[SCALE_LOG2 +: CW];
    row     = dy[SCALE_LOG2 +: RW];
`ifdef SPRITE_FLIP_EN
    col     = fx_q ? ~col_raw : col_raw;
`else
    col     = col_raw;
`endif
    addr_full   = {tsel_q, row, col};
    rom_address = hit ? addr_full[ADDR_W-1:0] : '0;
  end

  assign pal_index = rom_q;

  always_comb begin
    hit_d   = hit;
    blank_d = blank;
    rgb_d       = BG_RGB;
    sprite_on_d = 1'b0;
    if (!blank_q) begin
      rgb_d = 12'h000;
    end else if (hit_q && (rom_q != IDX_W'(KEY_IDX))) begin
      rgb_d       = pal_rgb;
      sprite_on_d = 1'b1;
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      px_q        <= '0;
      py_q        <= '0;
      tsel_q      <= '0;
`ifdef SPRITE_FLIP_EN
      fx_q        <= 1'b0;
`endif
      hit_q       <= 1'b0;
      blank_q     <= 1'b0;
      rgb_q       <= '0;
      sprite_on_q <= 1'b0;
    end else begin
      px_q        <= px_d;
      py_q        <= py_d;
      tsel_q      <= tsel_d;
`ifdef SPRITE_FLIP_EN
      fx_q        <= fx_d;
`endif
      hit_q       <= hit_d;
      blank_q     <= blank_d;
      rgb_q       <= rgb_d;
      sprite_on_q <= sprite_on_d;
    end
  end

  assign red       = rgb_q[11:8];
  assign green     = rgb_q[7:4];
  assign blue      = rgb_q[3:0];
  assign sprite_on = sprite_on_q;

endmodule
